// File: rtl/display_register_arbiter.sv
// ---------------------------------------------------------------------------
// display_register_arbiter
//
// Round-robin arbiter that lets four bus masters take turns owning the four
// display registers feeding the Seven_Segment_Display block. Only the current
// owner may write. A one-cycle idle bubble always separates two owners.
//
// Optional feature macro: DISPLAY_AUTOSCAN_EN
//   defined   : register_selection auto-advances every SCAN_DIV cycles while
//               auto_scan is high, otherwise follows sel_in.
//   undefined : register_selection simply follows sel_in; auto_scan ignored.
//
// Ports:
//   clk_clk            system clock
//   reset_reset_n      asynchronous active-low reset
//   req[3:0]           per-master level-held bus request
//   lock[3:0]          per-master lock, shields the owner from preemption
//   wr_en[3:0]         per-master write strobe
//   wr_addr[7:0]       per-master register index, 2 bits per master
//   wr_data            per-master write data, DATA_W bits per master
//   sel_in[1:0]        manual display selection
//   auto_scan          auto-scan enable (optional feature only)
//   grant[3:0]         registered one-hot grant
//   bus_busy           registered OR of grant
//   wr_reject          one-cycle pulse after a write from a non-owner
//   register_0..3      display registers
//   register_selection display register select
// ---------------------------------------------------------------------------
module display_register_arbiter #(
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8,
    parameter int SCAN_DIV = 50000000
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [3:0]            req,
    input  logic [3:0]            lock,
    input  logic [3:0]            wr_en,
    input  logic [7:0]            wr_addr,
    input  logic [4*DATA_W-1:0]   wr_data,
    input  logic [1:0]            sel_in,
    input  logic                  auto_scan,
    output logic [3:0]            grant,
    output logic                  bus_busy,
    output logic                  wr_reject,
    output logic [DATA_W-1:0]     register_0,
    output logic [DATA_W-1:0]     register_1,
    output logic [DATA_W-1:0]     register_2,
    output logic [DATA_W-1:0]     register_3,
    output logic [1:0]            register_selection
);

    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        rrPtr_q, rrPtr_d;
    logic [7:0]        holdCnt_q, holdCnt_d;
    logic [3:0]        grant_q, grant_d;
    logic              busy_q;
    logic              reject_q, reject_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [1:0]        sel_q;

    logic [1:0]        pick;
    logic              pickValid;
    logic [1:0]        cand;
    logic              ownerReq;
    logic [3:0]        others;
    logic              writeEn;
    logic [1:0]        writeAddr;
    logic [DATA_W-1:0] writeData;

    // Round-robin search: first requester at or after rrPtr, wrapping mod 4.
    always_comb begin
        pick      = '0;
        pickValid = 1'b0;
        cand      = '0;
        for (int j = 0; j < 4; j++) begin
            cand = rrPtr_q + 2'(j);
            if (!pickValid && req[cand]) begin
                pick      = cand;
                pickValid = 1'b1;
            end
        end
    end

    // Ownership FSM. Release (owner drops req) wins over preemption; both
    // return to IDLE so there is always a bubble, and both advance rrPtr
    // past the old owner so it goes to the back of the queue.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rrPtr_d   = rrPtr_q;
        holdCnt_d = holdCnt_q;
        grant_d   = grant_q;
        ownerReq  = req[owner_q];
        others    = req & ~(4'b0001 << owner_q);
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pickValid) begin
                    state_d   = OWNED;
                    owner_d   = pick;
                    holdCnt_d = 8'd1;
                    grant_d   = 4'b0001 << pick;
                end
            end
            OWNED: begin
                if (!ownerReq ||
                    (holdCnt_q >= MaxHold && !lock[owner_q] && others != 4'b0000)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    rrPtr_d   = owner_q + 2'd1;
                    holdCnt_d = '0;
                end else if (holdCnt_q != 8'hFF) begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Only the owner's write counts, and only while it still requests, so a
    // write on the release edge is dropped. Any strobe from a master that
    // does not hold the grant is folded into one reject pulse.
    always_comb begin
        writeEn   = (state_q == OWNED) && req[owner_q] && wr_en[owner_q];
        writeAddr = wr_addr[{owner_q, 1'b0} +: 2];
        writeData = wr_data[DATA_W*int'(owner_q) +: DATA_W];
        reject_d  = |(wr_en & ~grant_q);
    end

    // Arbiter state, grant, reject and the display registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rrPtr_q   <= '0;
            holdCnt_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            reject_q  <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rrPtr_q   <= rrPtr_d;
            holdCnt_q <= holdCnt_d;
            grant_q   <= grant_d;
            busy_q    <= |grant_d;
            reject_q  <= reject_d;
            if (writeEn) regs_q[writeAddr] <= writeData;
        end
    end

`ifdef DISPLAY_AUTOSCAN_EN
    localparam logic [31:0] ScanLast = 32'(SCAN_DIV - 1);
    logic [31:0] scanCnt_q;

    // Dwell counter: each full SCAN_DIV period steps the selection; leaving
    // auto-scan hands selection back to sel_in and restarts the dwell.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            scanCnt_q <= '0;
            sel_q     <= '0;
        end else if (auto_scan) begin
            if (scanCnt_q == ScanLast) begin
                scanCnt_q <= '0;
                sel_q     <= sel_q + 2'd1;
            end else begin
                scanCnt_q <= scanCnt_q + 32'd1;
            end
        end else begin
            scanCnt_q <= '0;
            sel_q     <= sel_in;
        end
    end
`else
    logic unusedAutoScan;
    assign unusedAutoScan = auto_scan & (SCAN_DIV != 0);

    // Manual selection registered once.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) sel_q <= '0;
        else                sel_q <= sel_in;
    end
`endif

    assign grant              = grant_q;
    assign bus_busy           = busy_q;
    assign wr_reject          = reject_q;
    assign register_0         = regs_q[0];
    assign register_1         = regs_q[1];
    assign register_2         = regs_q[2];
    assign register_3         = regs_q[3];
    assign register_selection = sel_q;

endmodule

// File: doc/display_register_arbiter.md
Name: display_register_arbiter

Overview:
- Round-robin arbiter that shares the four 16-bit display registers between four bus masters.
- Grants one master at a time and performs the granted master's register writes.
- Drives register_0..register_3 and register_selection into the Seven_Segment_Display block.
- Sits between the lab's bus masters and the display path.

Parameters:
- DATA_W, 16, width of each display register and each master's write data.
- MAX_HOLD, 8, cycles an unlocked owner may hold the grant before it is preempted when another master is waiting (range 1-255).
- SCAN_DIV, 50000000, clock cycles per display dwell in auto-scan mode (≥ 2).

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- req  in  4  per-master bus request, level-held
- lock  in  4  per-master lock; the owner is exempt from preemption while its bit is high
- wr_en  in  4  per-master write strobe
- wr_addr  in  8  per-master register index; master i uses bits [2i+1:2i]
- wr_data  in  4*DATA_W  per-master write data; master i uses bits [DATA_W*i+DATA_W-1:DATA_W*i]
- sel_in  in  2  manual display selection
- auto_scan  in  1  auto-scan enable; used only with the optional feature
- grant  out  4  one-hot registered grant
- bus_busy  out  1  high when any grant bit is high
- wr_reject  out  1  one-cycle pulse on a rejected write
- register_0 .. register_3  out  DATA_W each  display registers
- register_selection  out  2  display register select

Behaviour:
- Reset (async assert, sync release):
  - grant=0, bus_busy=0, wr_reject=0.
  - register_0..3=0, register_selection=0.
  - rr_ptr=0, hold_cnt=0, state=IDLE.
- FSM states: IDLE, OWNED(k).
- IDLE:
  - grant=0.
  - If req≠0, pick the first set req bit scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Next edge: grant[k]=1, state=OWNED(k), hold_cnt=1.
  - Latency from req to grant: 1 cycle when the bus is idle.
- OWNED(k), evaluated each edge in this priority order:
  1. req[k]=0: release. Next cycle state=IDLE, grant=0, rr_ptr=k+1 mod 4. A mandatory one-cycle idle bubble separates owners.
  2. hold_cnt≥MAX_HOLD, lock[k]=0, and (req & ~(1<<k))≠0: preempt. Handled like release (IDLE, rr_ptr=k+1).
  3. Otherwise stay in OWNED(k). hold_cnt increments, saturating at 255.
- lock[k] suppresses preemption only; dropping req[k] always releases.
- rr_ptr changes only on release or preempt.
- Writes:
  - On an edge with grant[k]=1 and req[k]=1 and wr_en[k]=1: register_(wr_addr_k) <= wr_data_k.
  - The new value is visible on the following cycle.
  - A write in the same cycle as the owner's release edge (req[k]=0) is not performed.
- Rejects:
  - wr_en[i]=1 for any i without a grant produces wr_reject=1 on the next cycle, for one cycle.
  - The rejected write is discarded.
  - Multiple simultaneous rejects produce a single pulse.
- grant is never multi-hot. bus_busy = |grant, registered.
- Simultaneous requests in IDLE are resolved solely by rr_ptr.
- Reset mid-burst: the grant drops immediately (asynchronous), registers clear, and arbitration restarts from master 0.

Optional Feature:
- Macro: DISPLAY_AUTOSCAN_EN.
- Defined:
  - A 32-bit dwell counter runs while auto_scan=1.
  - When the counter reaches SCAN_DIV-1, it wraps to 0 and register_selection advances 0→1→2→3→0.
  - auto_scan=0: the counter clears and register_selection <= sel_in, with 1-cycle latency.
  - Reset: counter=0, register_selection=0.
- Not defined:
  - register_selection <= sel_in every cycle, with 1-cycle latency.
  - auto_scan is ignored and no counter is synthesised.

Test Plan:
1. Reset, then req=4'b0001 and wr_en[0]=1 with wr_addr[1:0]=2, wr_data=16'h1A3C → grant=0001 one cycle after req; register_2=16'h1A3C one cycle after the first granted edge.
2. req=4'b1111 held, lock=0, MAX_HOLD=8 → grant sequence 0001, 0010, 0100, 1000, 0001. Each owner holds 8 cycles, each handover has a 1-cycle grant=0 bubble, grant is never multi-hot.
3. Master 1 owns with lock[1]=1 and req=4'b0011 for 20 cycles → grant stays 0010 for all 20 cycles. Clearing lock[1] then preempts on the next edge; master 0 is granted after the bubble.
4. Master 2 owns; master 3 pulses wr_en[3]=1 with data 16'hFFFF to addr 0 → wr_reject=1 for exactly one cycle; register_0 unchanged.
5. Assert reset_reset_n=0 mid-burst while grant=0100 and register_1=16'h00AB → grant, bus_busy and all registers read 0 before the next clock edge; after release with req=4'b1111, the first grant is 0001.
6. DISPLAY_AUTOSCAN_EN defined, SCAN_DIV=4, auto_scan=1 → register_selection steps 0,1,2,3,0 every 4 cycles. Setting auto_scan=0 with sel_in=2 gives register_selection=2 after 1 cycle.
